// File: rtl/eru8_vl.sv
// -----------------------------------------------------------------------------
// eru8_vl : variable-latency adder built on a block carry-speculative
//           approximate adder (bcsa_eru family).
//
// Each operand pair is added speculatively. The lower BLOCK bits are added
// exactly with carry-in 0. The upper block takes g[BLOCK-1] as its carry-in
// in place of the real lower-block carry-out. The speculation fails exactly
// when that guess differs from the real carry, and err flags that case.
//
// Build option (macro ERU_EXACT_FIX_EN):
//   defined   : a failed speculation costs one extra cycle in CORR, where the
//               exact sum is produced. sum is always exact, and err marks
//               results that were corrected.
//   undefined : CORR is never entered and every result has latency 1. sum is
//               the speculative sum, and err still flags wrong results.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous clear of op_cnt / err_cnt (FSM untouched)
//   in_valid   in   operands a/b present
//   in_ready   out  operands accepted when in_valid & in_ready
//   a, b       in   [WIDTH-1:0] unsigned operands
//   out_valid  out  result present
//   out_ready  in   consumer takes result when out_valid & out_ready
//   sum        out  [WIDTH:0] registered result including carry-out
//   err        out  registered speculation-failure flag for this result
//   op_cnt     out  [15:0] delivered results, saturating
//   err_cnt    out  [15:0] delivered results with err=1, saturating
// -----------------------------------------------------------------------------
module eru8_vl #(
   parameter int WIDTH = 8,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             err,
   output logic [15:0]      op_cnt,
   output logic [15:0]      err_cnt
);

   localparam int UPPER = WIDTH - BLOCK;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CORR = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t state, state_n;

   // ---------------------------------------------------------------------------
   // Speculative datapath (combinational from a/b, registered before output)
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] p, g;
   logic [BLOCK:0]   c_lo;       // ripple carries of the exact lower block
   logic [UPPER:0]   c_hi;       // ripple carries of the speculative upper block
   logic [WIDTH-1:0] spec_bits;
   logic [WIDTH:0]   spec_sum;
   logic             cl;         // true lower-block carry-out
   logic             spec_err;

   assign p = a ^ b;
   assign g = a & b;

   // NOTE: every signal driven by an always_comb gets a default at the top of
   // the block, so that no path leaves a value unassigned and a latch is
   // inferred.
   always_comb begin
      c_lo      = '0;
      c_hi      = '0;
      spec_bits = '0;
      for (int i = 0; i < BLOCK; i++) begin
         spec_bits[i] = p[i] ^ c_lo[i];
         c_lo[i+1]    = g[i] | (p[i] & c_lo[i]);
      end
      // The upper block guesses its carry-in from the top generate bit of the
      // lower block instead of waiting for the lower ripple to finish.
      c_hi[0] = g[BLOCK-1];
      for (int j = 0; j < UPPER; j++) begin
         spec_bits[BLOCK+j] = p[BLOCK+j] ^ c_hi[j];
         c_hi[j+1]          = g[BLOCK+j] | (p[BLOCK+j] & c_hi[j]);
      end
   end

   assign cl       = c_lo[BLOCK];
   assign spec_err = cl ^ g[BLOCK-1];
   assign spec_sum = {c_hi[UPPER], spec_bits};

`ifdef ERU_EXACT_FIX_EN
   // Operands of a mis-speculated add are held for the correction cycle.
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH:0]   exact_sum;

   assign exact_sum = {1'b0, a_q} + {1'b0, b_q};
`endif

   // ---------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------
   logic accept;   // input handshake this cycle
   logic deliver;  // output handshake this cycle

   // in_ready depends on state and out_ready only, never on in_valid.
   assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;
   assign deliver   = out_valid & out_ready;

   // ---------------------------------------------------------------------------
   // FSM: next state and datapath load enables
   // ---------------------------------------------------------------------------
   logic load_spec;   // capture speculative sum and err flag
   logic load_exact;  // capture exact sum (correction cycle)
   logic latch_ops;   // hold operands for the correction cycle

   always_comb begin
      state_n    = state;
      load_spec  = 1'b0;
      load_exact = 1'b0;
      latch_ops  = 1'b0;
      // A new operand is dispatched the same way from IDLE and from HOLD when
      // the pending result leaves in the same cycle.
      unique case (state)
         IDLE: begin
            if (accept) begin
`ifdef ERU_EXACT_FIX_EN
               if (spec_err) begin
                  latch_ops = 1'b1;
                  state_n   = CORR;
               end else begin
                  load_spec = 1'b1;
                  state_n   = HOLD;
               end
`else
               load_spec = 1'b1;
               state_n   = HOLD;
`endif
            end
         end
         CORR: begin
            load_exact = 1'b1;
            state_n    = HOLD;
         end
         HOLD: begin
            if (deliver) begin
               if (accept) begin
`ifdef ERU_EXACT_FIX_EN
                  if (spec_err) begin
                     latch_ops = 1'b1;
                     state_n   = CORR;
                  end else begin
                     load_spec = 1'b1;
                     state_n   = HOLD;
                  end
`else
                  load_spec = 1'b1;
                  state_n   = HOLD;
`endif
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the values from before the edge regardless of
   // the order in which the blocks are evaluated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // ---------------------------------------------------------------------------
   // Result register. It holds its value in HOLD until the result is taken.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
         err <= 1'b0;
      end else if (load_spec) begin
         sum <= spec_sum;
         err <= spec_err;
`ifdef ERU_EXACT_FIX_EN
      end else if (load_exact) begin
         sum <= exact_sum;
         err <= 1'b1;
`endif
      end
   end

`ifdef ERU_EXACT_FIX_EN
   // NOTE: the operand holding register is reset along with everything else.
   // It is only a few flops, and reset keeps simulation free of X values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else if (latch_ops) begin
         a_q <= a;
         b_q <= b;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Statistics counters: saturating, and clr has priority over an increment
   // in the same cycle.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt  <= '0;
         err_cnt <= '0;
      end else if (clr) begin
         op_cnt  <= '0;
         err_cnt <= '0;
      end else if (deliver) begin
         if (op_cnt != 16'hFFFF) begin
            op_cnt <= op_cnt + 16'd1;
         end
         if (err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
         end
      end
   end

   // load_exact has no consumer when the correction path is compiled out.
`ifndef ERU_EXACT_FIX_EN
   logic unused_ok;
   assign unused_ok = load_exact | latch_ops;
`endif

endmodule

// File: tb/tb_eru8_vl.sv
// -----------------------------------------------------------------------------
// tb_eru8_vl : directed self-checking bench for eru8_vl.
// Expected values are hand-computed. Expectations that depend on the build
// follow ERU_EXACT_FIX_EN, because the bench is compiled with the same macros
// as the design.
// -----------------------------------------------------------------------------
module tb_eru8_vl;

`ifdef ERU_EXACT_FIX_EN
   localparam bit FIX = 1'b1;
`else
   localparam bit FIX = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  sum;
   logic        err;
   logic [15:0] op_cnt;
   logic [15:0] err_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   eru8_vl #(.WIDTH(8), .BLOCK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .err       (err),
      .op_cnt    (op_cnt),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operand pair with out_ready high and follow it to delivery.
   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [8:0] exp_sum, input logic exp_err,
                         input logic [15:0] exp_op, input logic [15:0] exp_ec);
      a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      if (FIX && exp_err) begin
         check({tag, "_corr_no_out"}, 32'(out_valid), 32'd0);
         check({tag, "_corr_in_ready"}, 32'(in_ready), 32'd0);
         tick();
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      tick();
      check({tag, "_op_cnt"}, 32'(op_cnt), 32'(exp_op));
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_ec));
      check({tag, "_idle"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_op_cnt", 32'(op_cnt), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      tick();

      // Single operations: no error, then errors resolved or left approximate.
      run_op("add_08_08", 8'h08, 8'h08, 9'h010, 1'b0, 16'd1, 16'd0);
      run_op("add_0f_01", 8'h0F, 8'h01, FIX ? 9'h010 : 9'h000, 1'b1, 16'd2, 16'd1);
      run_op("add_3f_01", 8'h3F, 8'h01, FIX ? 9'h040 : 9'h030, 1'b1, 16'd3, 16'd2);
      run_op("add_ff_01", 8'hFF, 8'h01, FIX ? 9'h100 : 9'h0F0, 1'b1, 16'd4, 16'd3);
      run_op("add_7f_08", 8'h7F, 8'h08, 9'h087, 1'b0, 16'd5, 16'd3);

      // clr while idle.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_idle_op", 32'(op_cnt), 32'd0);
      check("clr_idle_err", 32'(err_cnt), 32'd0);

      // Back-to-back stream with both sides held ready.
      a = 8'hFF; b = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      check("strm0_sum", 32'(sum), 32'h1FE);
      check("strm0_in_ready", 32'(in_ready), 32'd1);
      a = 8'h01; b = 8'h02;
      tick();
      check("strm1_sum", 32'(sum), 32'h003);
      check("strm1_in_ready", 32'(in_ready), 32'd1);
      check("strm1_valid", 32'(out_valid), 32'd1);
      a = 8'h80; b = 8'h80;
      tick();
      check("strm2_sum", 32'(sum), 32'h100);
      check("strm2_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      tick();
      check("strm_op_cnt", 32'(op_cnt), 32'd3);
      check("strm_idle", 32'(out_valid), 32'd0);

      // Back-pressure: the result is held stable while out_ready is low.
      a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      a = 8'h05; b = 8'h06;
      for (int k = 0; k < 3; k++) begin
         check("hold_sum", 32'(sum), 32'h046);
         check("hold_err", 32'(err), 32'd0);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_op_cnt", 32'(op_cnt), 32'd3);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("hold_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("hold_both_op_cnt", 32'(op_cnt), 32'd4);
      check("hold_both_sum", 32'(sum), 32'h00B);
      check("hold_both_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      check("hold_final_op_cnt", 32'(op_cnt), 32'd5);

      // clr on a delivery cycle of an erroneous result wins over both increments.
      a = 8'h0F; b = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      if (FIX) tick();
      check("clr_hs_valid", 32'(out_valid), 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_hs_op", 32'(op_cnt), 32'd0);
      check("clr_hs_err", 32'(err_cnt), 32'd0);
      check("clr_hs_fsm", 32'(out_valid), 32'd0);

      // Preload op_cnt to saturation with an error-free stream.
      a = 8'h01; b = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
      guard = 0;
      while (op_cnt != 16'hFFFF && guard < 70000) begin
         tick();
         guard++;
      end
      check("sat_reached", 32'(op_cnt), 32'hFFFF);
      in_valid = 1'b0;
      tick();
      check("sat_hold_pending", 32'(op_cnt), 32'hFFFF);
      run_op("sat_extra", 8'h02, 8'h03, 9'h005, 1'b0, 16'hFFFF, 16'd0);

      // Reset while an erroneous operand is in flight (CORR, or HOLD without the fix).
      a = 8'h0F; b = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check("inflight_valid", 32'(out_valid), FIX ? 32'd0 : 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_sum", 32'(sum), 32'd0);
      check("rst_mid_err", 32'(err), 32'd0);
      check("rst_mid_op_cnt", 32'(op_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      check("rst_after_valid", 32'(out_valid), 32'd0);
      check("rst_after_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("rst_after_op_cnt", 32'(op_cnt), 32'd0);
      check("rst_after_err_cnt", 32'(err_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
